unidade_busca: RTL and testbench

Instruction-fetch stage of the 8-bit processor, sitting directly upstream of the instruction memory. It owns the program counter and drives the memory address. It captures the byte the memory returns into an instruction register and presents it, with a valid flag and its fetch address, to the decode stage. Also handles stall, taken-branch redirect (with discard of the in-flight fetch) and a halt opcode.

---
 rtl/unidade_busca.sv | 93 +++++++++
 tb/tb_unidade_busca.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_busca.sv
// Instruction-fetch stage: owns the PC, captures the instruction byte returned by
// memory into the IR and hands it to decode with its fetch address and a valid flag.
module unidade_busca #(
    parameter logic [7:0] ENDERECO_INICIAL = 8'h00,
    parameter logic [7:0] OPCODE_HALT      = 8'h00
) (
    input  logic       Clock,
    input  logic       Reset,
    output logic [7:0] Endereco,
    input  logic [7:0] Instrucao,
    input  logic       Desvio,
    input  logic [7:0] AlvoDesvio,
    input  logic       Parar,
    output logic [7:0] InstrucaoIR,
    output logic [7:0] PCInstrucao,
    output logic       Valida,
    output logic       Parado
);

    typedef enum logic [1:0] {
        INICIO,
        BUSCA,
        PARADO
    } estado_t;

    estado_t    estado, estado_prox;
    logic [7:0] endereco_prox;
    logic [7:0] ir_prox;
    logic [7:0] pc_ir_prox;
    logic       valida_prox;
    logic       parado_prox;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            estado      <= INICIO;
            Endereco    <= ENDERECO_INICIAL;
            InstrucaoIR <= 8'h00;
            PCInstrucao <= 8'h00;
            Valida      <= 1'b0;
            Parado      <= 1'b0;
        end else begin
            estado      <= estado_prox;
            Endereco    <= endereco_prox;
            InstrucaoIR <= ir_prox;
            PCInstrucao <= pc_ir_prox;
            Valida      <= valida_prox;
            Parado      <= parado_prox;
        end
    end

    // NOTE: every output of this block gets a hold value first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        estado_prox   = estado;
        endereco_prox = Endereco;
        ir_prox       = InstrucaoIR;
        pc_ir_prox    = PCInstrucao;
        valida_prox   = Valida;
        parado_prox   = Parado;

        case (estado)
            INICIO: begin
                // Idle edge: memory gets a full negedge on a stable address first.
                if (Desvio) endereco_prox = AlvoDesvio;
                estado_prox = BUSCA;
            end
            BUSCA: begin
                if (Desvio) begin
                    endereco_prox = AlvoDesvio;
                    valida_prox   = 1'b0;
                end else if (!Parar) begin
                    ir_prox     = Instrucao;
                    pc_ir_prox  = Endereco;
                    valida_prox = 1'b1;
                    if (Instrucao == OPCODE_HALT) begin
                        parado_prox = 1'b1;
                        estado_prox = PARADO;
                    end else begin
                        endereco_prox = Endereco + 8'd1;
                    end
                end
            end
            PARADO: begin
                // Halt instruction stays valid until decode is not stalled.
                if (!Parar) valida_prox = 1'b0;
            end
            default: estado_prox = INICIO;
        endcase
    end

endmodule

// File: tb/tb_unidade_busca.sv
// Bench for unidade_busca: two instances (halt opcodes 00 and A5) on a memory holding
// 255-i at address i, checked every cycle against a behavioural fetch model.
module tb_unidade_busca;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       Desvio = 1'b0;
    logic       Parar = 1'b0;
    logic [7:0] AlvoDesvio = 8'h00;

    logic [7:0] end_a, instr_a, ir_a, pci_a;
    logic       val_a, par_a;
    logic [7:0] end_b, instr_b, ir_b, pci_b;
    logic       val_b, par_b;

    int n_checks = 0;
    int n_fails  = 0;

    unidade_busca #(.ENDERECO_INICIAL(8'h00), .OPCODE_HALT(8'h00)) dut_a (
        .Clock(Clock), .Reset(Reset), .Endereco(end_a), .Instrucao(instr_a),
        .Desvio(Desvio), .AlvoDesvio(AlvoDesvio), .Parar(Parar),
        .InstrucaoIR(ir_a), .PCInstrucao(pci_a), .Valida(val_a), .Parado(par_a)
    );

    unidade_busca #(.ENDERECO_INICIAL(8'h00), .OPCODE_HALT(8'hA5)) dut_b (
        .Clock(Clock), .Reset(Reset), .Endereco(end_b), .Instrucao(instr_b),
        .Desvio(Desvio), .AlvoDesvio(AlvoDesvio), .Parar(Parar),
        .InstrucaoIR(ir_b), .PCInstrucao(pci_b), .Valida(val_b), .Parado(par_b)
    );

    always #5 Clock = ~Clock;

    // Instruction memory: byte 255-i at address i, refreshed on each negedge.
    always @(negedge Clock) begin
        instr_a <= 8'hFF - end_a;
        instr_b <= 8'hFF - end_b;
    end

    // Behavioural model: what decode should see, derived from the program in memory.
    typedef struct {
        bit         started;
        bit         halted;
        logic [7:0] pc;
        logic [7:0] ir;
        logic [7:0] pci;
        bit         valid;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.started = 1'b0;
        m.halted  = 1'b0;
        m.pc      = 8'h00;
        m.ir      = 8'h00;
        m.pci     = 8'h00;
        m.valid   = 1'b0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, bit d, logic [7:0] a, bit p, logic [7:0] halt_op);
        logic [7:0] fetched;
        fetched = 8'hFF - m.pc;
        if (!m.started) begin
            if (d) m.pc = a;
            m.started = 1'b1;
        end else if (m.halted) begin
            if (!p) m.valid = 1'b0;
        end else if (d) begin
            m.pc    = a;
            m.valid = 1'b0;
        end else if (!p) begin
            m.ir    = fetched;
            m.pci   = m.pc;
            m.valid = 1'b1;
            if (fetched == halt_op) m.halted = 1'b1;
            else                    m.pc = m.pc + 8'd1;
        end
        return m;
    endfunction

    mdl_t ma, mb;

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ma <= mdl_reset();
            mb <= mdl_reset();
        end else begin
            ma <= mdl_step(ma, Desvio, AlvoDesvio, Parar, 8'h00);
            mb <= mdl_step(mb, Desvio, AlvoDesvio, Parar, 8'hA5);
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge Clock) begin
        #1;
        if (Reset) begin
            check("a.endereco", end_a, ma.pc);
            check("a.ir",       ir_a,  ma.ir);
            check("a.pc_ir",    pci_a, ma.pci);
            check("a.valida",   {7'b0, val_a}, {7'b0, ma.valid});
            check("a.parado",   {7'b0, par_a}, {7'b0, ma.halted});
            check("b.endereco", end_b, mb.pc);
            check("b.ir",       ir_b,  mb.ir);
            check("b.pc_ir",    pci_b, mb.pci);
            check("b.valida",   {7'b0, val_b}, {7'b0, mb.valid});
            check("b.parado",   {7'b0, par_b}, {7'b0, mb.halted});
        end
    end

    task automatic cycle(input bit d, input logic [7:0] a, input bit p);
        @(negedge Clock);
        Desvio     = d;
        AlvoDesvio = a;
        Parar      = p;
        @(posedge Clock);
        #2;
    endtask

    task automatic expect_a(input string name, input logic [7:0] pcv, input logic [7:0] irv);
        check({name, ".valida"}, {7'b0, val_a}, 8'h01);
        check({name, ".pc_ir"},  pci_a, pcv);
        check({name, ".ir"},     ir_a,  irv);
    endtask

    // Reset pulse between edges; outputs must clear before the next posedge.
    task automatic reset_pulse();
        @(negedge Clock);
        Desvio = 1'b0;
        Parar  = 1'b0;
        #2 Reset = 1'b0;
        #1;
        check("rst.a.valida",   {7'b0, val_a}, 8'h00);
        check("rst.a.endereco", end_a, 8'h00);
        check("rst.a.parado",   {7'b0, par_a}, 8'h00);
        check("rst.b.valida",   {7'b0, val_b}, 8'h00);
        check("rst.b.endereco", end_b, 8'h00);
        #1 Reset = 1'b1;
        @(posedge Clock);
        #2;
        check("inicio.valida", {7'b0, val_a}, 8'h00);
        check("inicio.endereco", end_a, 8'h00);
    endtask

    task automatic start_sequence();
        cycle(1'b0, 8'h00, 1'b0); expect_a("s1.0", 8'h00, 8'hFF);
        cycle(1'b0, 8'h00, 1'b0); expect_a("s1.1", 8'h01, 8'hFE);
        cycle(1'b0, 8'h00, 1'b0); expect_a("s1.2", 8'h02, 8'hFD);
    endtask

    initial begin
        repeat (2) @(posedge Clock);
        #1;
        check("reset.endereco", end_a, 8'h00);
        check("reset.ir",       ir_a,  8'h00);
        check("reset.pc_ir",    pci_a, 8'h00);
        check("reset.valida",   {7'b0, val_a}, 8'h00);
        check("reset.parado",   {7'b0, par_a}, 8'h00);

        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        #2;
        check("inicio.valida", {7'b0, val_a}, 8'h00);
        check("inicio.endereco", end_a, 8'h00);
        start_sequence();

        // Taken branch: one bubble, address 03 never presented.
        cycle(1'b1, 8'hF0, 1'b0);
        check("br.valida", {7'b0, val_a}, 8'h00);
        check("br.pc_ir_held", pci_a, 8'h02);
        check("br.endereco", end_a, 8'hF0);
        cycle(1'b0, 8'h00, 1'b0); expect_a("br.0", 8'hF0, 8'h0F);
        cycle(1'b0, 8'h00, 1'b0); expect_a("br.1", 8'hF1, 8'h0E);

        // Stall at PCInstrucao=05.
        cycle(1'b1, 8'h03, 1'b0);
        cycle(1'b0, 8'h00, 1'b0); expect_a("st.3", 8'h03, 8'hFC);
        cycle(1'b0, 8'h00, 1'b0); expect_a("st.4", 8'h04, 8'hFB);
        cycle(1'b0, 8'h00, 1'b0); expect_a("st.5", 8'h05, 8'hFA);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 1'b1); expect_a("st.hold", 8'h05, 8'hFA);
        end
        cycle(1'b0, 8'h00, 1'b0); expect_a("st.6", 8'h06, 8'hF9);
        cycle(1'b1, 8'h10, 1'b1);
        check("stbr.valida", {7'b0, val_a}, 8'h00);
        check("stbr.endereco", end_a, 8'h10);
        cycle(1'b0, 8'h00, 1'b0); expect_a("stbr.0", 8'h10, 8'hEF);

        // Halt on A at FF; B (halt A5) wraps past FF.
        cycle(1'b1, 8'hFD, 1'b0);
        cycle(1'b0, 8'h00, 1'b0); expect_a("h.fd", 8'hFD, 8'h02);
        cycle(1'b0, 8'h00, 1'b0); expect_a("h.fe", 8'hFE, 8'h01);
        cycle(1'b0, 8'h00, 1'b0); expect_a("h.ff", 8'hFF, 8'h00);
        check("h.parado", {7'b0, par_a}, 8'h01);
        check("h.endereco", end_a, 8'hFF);
        check("w.endereco", end_b, 8'h00);
        check("w.parado", {7'b0, par_b}, 8'h00);
        cycle(1'b0, 8'h00, 1'b0);
        check("h.valida_drop", {7'b0, val_a}, 8'h00);
        check("w.pc_ir", pci_b, 8'h00);
        check("w.ir", ir_b, 8'hFF);
        for (int i = 0; i < 10; i++) begin
            cycle(i[0], 8'($urandom), 1'b0);
            check("h.frozen_endereco", end_a, 8'hFF);
            check("h.frozen_parado", {7'b0, par_a}, 8'h01);
        end

        // Mid-stream reset, then the start sequence repeats.
        reset_pulse();
        start_sequence();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) reset_pulse();
            else cycle($urandom_range(0, 9) == 0, 8'($urandom), $urandom_range(0, 6) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
